mdu_ctrl: RTL and testbench

Multiply/divide unit controller for the E stage of the five-stage MIPS pipeline. Accepts mult/div/mthi/mtlo operations alongside ALU ops, models fixed multi-cycle latency with a busy counter, owns the HI/LO registers, and exports busy/start to the hazard unit so D-stage md instructions stall. An exception flush (`req`) suppresses an E-stage operation in the same cycle, matching how the E→M register is flushed.

---
 rtl/mdu_ctrl_pkg.sv | 46 ++++
 rtl/mdu_arith.sv | 72 +++++++
 rtl/mdu_ctrl.sv | 111 +++++++++++
 tb/tb_mdu_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mdu_ctrl_pkg
// Shared definitions for the E-stage multiply/divide unit: md op-code
// encoding (also used by the decoder), controller state encoding, default
// latencies and small op-classification helpers.
// Optional feature macro: MDU_MADD_EN (adds MADD/MADDU/MSUB to the md-op set).
// ---------------------------------------------------------------------------
package mdu_ctrl_pkg;

    // md op codes carried down the pipeline in E_mdop
    localparam logic [3:0] MDOP_NONE  = 4'd0;
    localparam logic [3:0] MDOP_MULT  = 4'd1;
    localparam logic [3:0] MDOP_MULTU = 4'd2;
    localparam logic [3:0] MDOP_DIV   = 4'd3;
    localparam logic [3:0] MDOP_DIVU  = 4'd4;
    localparam logic [3:0] MDOP_MTHI  = 4'd5;
    localparam logic [3:0] MDOP_MTLO  = 4'd6;
    localparam logic [3:0] MDOP_MADD  = 4'd7;
    localparam logic [3:0] MDOP_MADDU = 4'd8;
    localparam logic [3:0] MDOP_MSUB  = 4'd9;

    // controller state encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // default latencies (busy cycles after start)
    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    // True for ops that occupy the unit (start the busy sequence).
    function automatic logic is_md_op(input logic [3:0] op);
        case (op)
            MDOP_MULT, MDOP_MULTU, MDOP_DIV, MDOP_DIVU: is_md_op = 1'b1;
`ifdef MDU_MADD_EN
            MDOP_MADD, MDOP_MADDU, MDOP_MSUB:           is_md_op = 1'b1;
`endif
            default:                                    is_md_op = 1'b0;
        endcase
    endfunction

    // Divides use the longer latency; everything else uses the multiply one.
    function automatic logic is_div_op(input logic [3:0] op);
        is_div_op = (op == MDOP_DIV) || (op == MDOP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// ---------------------------------------------------------------------------
// mdu_arith
// Purely combinational 64-bit result generator for the multiply/divide unit.
// The controller samples the result in the start cycle and commits it to
// HI/LO after the modelled latency.
// Optional feature macro: MDU_MADD_EN (accumulating multiplies).
//
// Ports:
//   op           in  4   md op code
//   rs, rt       in  32  forwarded operands
//   hilo         in  64  current {hi,lo} (accumulate base / pass-through)
//   result       out 64  {hi,lo} to commit
//   result_valid out 1   0 when hi/lo must be left unchanged (divide by zero)
// ---------------------------------------------------------------------------
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [63:0] hilo,
    output logic [63:0] result,
    output logic        result_valid
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] divisor;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;

    // Sign-extending both operands to 64 bits makes the low 64 bits of the
    // product equal to the signed 32x32 product.
    assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign prod_u = {32'b0, rs} * {32'b0, rt};

    // A zero divisor is replaced so the dividers never produce X; the
    // result is discarded via result_valid anyway.
    assign divisor = (rt == 32'd0) ? 32'd1 : rt;
    assign quot_s  = $signed(rs) / $signed(divisor);
    assign rem_s   = $signed(rs) % $signed(divisor);
    assign quot_u  = rs / divisor;
    assign rem_u   = rs % divisor;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        result       = hilo;
        result_valid = 1'b1;
        case (op)
            MDOP_MULT:  result = prod_s;
            MDOP_MULTU: result = prod_u;
            MDOP_DIV: begin
                result       = {rem_s, quot_s};
                result_valid = (rt != 32'd0);
            end
            MDOP_DIVU: begin
                result       = {rem_u, quot_u};
                result_valid = (rt != 32'd0);
            end
`ifdef MDU_MADD_EN
            MDOP_MADD:  result = hilo + prod_s;
            MDOP_MADDU: result = hilo + prod_u;
            MDOP_MSUB:  result = hilo - prod_s;
`endif
            default:    result = hilo;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_ctrl
// E-stage multiply/divide controller: accepts md ops, models fixed latency
// with a busy counter, owns HI/LO, and exports start/busy to the hazard unit
// so D-stage md/mfhi/mflo instructions stall while start|busy.
// Optional feature macro: MDU_MADD_EN (MADD/MADDU/MSUB accepted).
//
// Parameters:
//   MULT_CYCLES  busy cycles after a multiply-class start (default 5)
//   DIV_CYCLES   busy cycles after a divide start (default 10)
// Ports:
//   clk     in  1   clock
//   reset   in  1   synchronous, active-high reset
//   req     in  1   exception flush; cancels the E-stage op this cycle
//   E_mdop  in  4   md op code
//   E_rs    in  32  forwarded rs
//   E_rt    in  32  forwarded rt
//   start   out 1   combinational; md op accepted this cycle
//   busy    out 1   operation in flight
//   hi, lo  out 32  HI/LO registers
// ---------------------------------------------------------------------------
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [3:0]  E_mdop,
    input  logic [31:0] E_rs,
    input  logic [31:0] E_rt,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [0:0]       state;
    logic [CNT_W-1:0] count;
    logic [63:0]      shadow;
    logic             shadow_valid;
    logic [63:0]      arith_result;
    logic             arith_valid;
    logic             idle_accept;

    mdu_arith u_arith (
        .op           (E_mdop),
        .rs           (E_rs),
        .rt           (E_rt),
        .hilo         ({hi, lo}),
        .result       (arith_result),
        .result_valid (arith_valid)
    );

    // Ops are only taken when idle and not flushed; anything seen while
    // busy is a hazard-unit failure and is dropped.
    assign idle_accept = (state == ST_IDLE) && !req;
    assign start       = idle_accept && is_md_op(E_mdop);
    assign busy        = (state == ST_RUN);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state <= ST_IDLE;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        count <= is_div_op(E_mdop) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    end else if (idle_accept && (E_mdop == MDOP_MTHI)) begin
                        hi <= E_rs;
                    end else if (idle_accept && (E_mdop == MDOP_MTLO)) begin
                        lo <= E_rs;
                    end
                end
                ST_RUN: begin
                    // Commit on the last busy cycle so new hi/lo appear
                    // together with busy falling.
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state <= ST_IDLE;
                        if (shadow_valid) begin
                            {hi, lo} <= shadow;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the shadow pair is pure datapath and is only read after a start
    // has loaded it, so it carries no reset.
    always_ff @(posedge clk) begin
        if (start) begin
            shadow       <= arith_result;
            shadow_valid <= arith_valid;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mdu_ctrl
// Self-checking bench for mdu_ctrl. Expected {hi,lo} and latency are pushed
// to a scoreboard queue when an md op is issued and popped when busy falls.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// (start is sampled 1 ns after its inputs settle).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        req    = 1'b0;
    logic [3:0]  E_mdop = MDOP_NONE;
    logic [31:0] E_rs   = '0;
    logic [31:0] E_rt   = '0;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .E_mdop (E_mdop),
        .E_rs   (E_rs),
        .E_rt   (E_rt),
        .start  (start),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_hi    = '0;   // bench model of HI
    logic [31:0] m_lo    = '0;   // bench model of LO

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one md op and follow it to commit.
    // mode 0: plain; 1: MULT and MTLO driven while busy; 2: req pulsed while busy.
    task automatic run_md(input string tag, input logic [3:0] op,
                          input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int cycles, input int mode);
        exp_t e;
        int   cnt;
        int   guard;
        @(negedge clk);
        E_mdop = op;
        E_rs   = rs;
        E_rt   = rt;
        #1;
        check({tag, ".start"}, 64'(start), 64'd1);
        check({tag, ".busy_at_start"}, 64'(busy), 64'd0);
        e = '{tag, exp_hi, exp_lo, cycles};
        exp_q.push_back(e);
        @(negedge clk);
        E_mdop = MDOP_NONE;
        E_rs   = '0;
        E_rt   = '0;
        cnt    = 0;
        guard  = 0;
        while (busy === 1'b1 && guard < 60) begin
            cnt++;
            guard++;
            if (mode == 1 && cnt == 2) begin
                E_mdop = MDOP_MULT;
                E_rs   = 32'd7;
                E_rt   = 32'd7;
                #1;
                check({tag, ".start_while_busy"}, 64'(start), 64'd0);
            end
            if (mode == 1 && cnt == 3) begin
                E_mdop = MDOP_MTLO;
                E_rs   = 32'h0000_1234;
            end
            if (mode == 1 && cnt == 4) E_mdop = MDOP_NONE;
            if (mode == 2 && cnt == 2) req = 1'b1;
            if (mode == 2 && cnt == 4) req = 1'b0;
            if (cnt == cycles) begin
                // last busy cycle: old values still visible (no bypass)
                check({tag, ".hi_before_commit"}, 64'(hi), 64'(m_hi));
                check({tag, ".lo_before_commit"}, 64'(lo), 64'(m_lo));
            end
            @(negedge clk);
        end
        E_mdop = MDOP_NONE;
        E_rs   = '0;
        req    = 1'b0;
        e = exp_q.pop_front();
        check({e.tag, ".busy_cycles"}, 64'(cnt), 64'(e.cycles));
        check({e.tag, ".hi"}, 64'(hi), 64'(e.hi));
        check({e.tag, ".lo"}, 64'(lo), 64'(e.lo));
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    task automatic mt_write(input string tag, input logic [3:0] op, input logic [31:0] val);
        @(negedge clk);
        E_mdop = op;
        E_rs   = val;
        #1;
        check({tag, ".start"}, 64'(start), 64'd0);
        @(negedge clk);
        E_mdop = MDOP_NONE;
        E_rs   = '0;
        if (op == MDOP_MTHI) m_hi = val;
        else                 m_lo = val;
        check({tag, ".busy"}, 64'(busy), 64'd0);
        check({tag, ".hi"}, 64'(hi), 64'(m_hi));
        check({tag, ".lo"}, 64'(lo), 64'(m_lo));
    endtask

    // Drive an op that must not be accepted; hi/lo and busy must stay put.
    task automatic no_accept(input string tag, input logic [3:0] op, input logic flush);
        @(negedge clk);
        E_mdop = op;
        E_rs   = 32'd5;
        E_rt   = 32'd9;
        req    = flush;
        #1;
        check({tag, ".start"}, 64'(start), 64'd0);
        @(negedge clk);
        E_mdop = MDOP_NONE;
        req    = 1'b0;
        check({tag, ".busy"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({tag, ".busy_later"}, 64'(busy), 64'd0);
        check({tag, ".hi"}, 64'(hi), 64'(m_hi));
        check({tag, ".lo"}, 64'(lo), 64'(m_lo));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        longint      ps;
        logic [63:0] pu;

        repeat (2) @(negedge clk);
        check("reset.busy",  64'(busy),  64'd0);
        check("reset.start", 64'(start), 64'd0);
        check("reset.hi",    64'(hi),    64'd0);
        check("reset.lo",    64'(lo),    64'd0);
        reset = 1'b0;

        run_md("mult_neg",  MDOP_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MULT_N, 1);
        run_md("divu_17_5", MDOP_DIVU, 32'd17, 32'd5, 32'd2, 32'd3, DIV_N, 0);
        run_md("div_m17_5", MDOP_DIV, 32'hFFFF_FFEF, 32'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_N, 0);

        mt_write("mthi_11", MDOP_MTHI, 32'h11);
        mt_write("mtlo_22", MDOP_MTLO, 32'h22);
        run_md("div_by_zero", MDOP_DIV, 32'd9, 32'd0, 32'h11, 32'h22, DIV_N, 0);

        no_accept("mult_flushed", MDOP_MULT, 1'b1);
        run_md("mult_req_run", MDOP_MULT, 32'd6, 32'd7, 32'd0, 32'd42, MULT_N, 2);

        for (int i = 0; i < 3; i++) begin
            a  = $urandom();
            b  = $urandom();
            ps = longint'($signed(a)) * longint'($signed(b));
            run_md("rand_mult", MDOP_MULT, a, b, ps[63:32], ps[31:0], MULT_N, 0);
            pu = 64'(a) * 64'(b);
            run_md("rand_multu", MDOP_MULTU, a, b, pu[63:32], pu[31:0], MULT_N, 0);
            b = $urandom_range(1, 1000);
            run_md("rand_divu", MDOP_DIVU, a, b, a % b, a / b, DIV_N, 0);
        end

        mt_write("mtlo_dead", MDOP_MTLO, 32'hDEAD_BEEF);
        @(negedge clk);
        check("mtlo_dead.busy_after", 64'(busy), 64'd0);

        // reset in the 3rd busy cycle of a divide
        @(negedge clk);
        E_mdop = MDOP_DIV;
        E_rs   = 32'd100;
        E_rt   = 32'd7;
        @(negedge clk);
        E_mdop = MDOP_NONE;
        check("rst_mid.busy1", 64'(busy), 64'd1);
        @(negedge clk);
        @(negedge clk);
        check("rst_mid.busy3", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi  = '0;
        m_lo  = '0;
        check("rst_mid.busy", 64'(busy), 64'd0);
        check("rst_mid.hi",   64'(hi),   64'd0);
        check("rst_mid.lo",   64'(lo),   64'd0);
        @(negedge clk);
        check("rst_mid.busy_later", 64'(busy), 64'd0);

`ifdef MDU_MADD_EN
        mt_write("madd_hi0", MDOP_MTHI, 32'd0);
        mt_write("madd_lo1", MDOP_MTLO, 32'd1);
        run_md("madd_2x3",   MDOP_MADD,  32'd2, 32'd3, 32'd0, 32'd7, MULT_N, 0);
        run_md("msub_1x8",   MDOP_MSUB,  32'd1, 32'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_N, 0);
        run_md("maddu_big",  MDOP_MADDU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFD, MULT_N, 0);
`else
        no_accept("code7_none", MDOP_MADD, 1'b0);
        no_accept("code9_none", MDOP_MSUB, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
